// File: rtl/dcache_blocking_mem_arb.sv
// -----------------------------------------------------------------------------
// dcache_blocking_mem_arb
//
// Shares one line-granularity memory port between N_REQ blocking requesters.
// Commands are granted one at a time in round-robin order. The port stays
// owned until the transaction ends:
//   - a writeback ends on its last write-data beat;
//   - a fill ends on its last memory response beat.
// The owner's write beats are forwarded to memory. Memory response beats are
// steered back to the owner only. Every output is registered.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/wrbk/addr     per-requester command; valid is held until granted
//   req_dat_valid/sop/eop   per-requester write-data beat
//   req_dat                 per-requester write-data beat payload
//   req_gnt_r               one-hot, single-cycle grant pulse
//   rsp_valid_r             one-hot response beat valid (owner only)
//   rsp_sop_r/eop_r/dat_r   response beat, broadcast to all requesters
//   mem_valid_r/wrbk_r/addr_r            command to memory (one cycle)
//   mem_dat_valid_r/sop_r/eop_r/dat_r    write beat to memory
//   mem_rsp_valid/sop/eop/dat            response beat from memory
//   arb_busy_r              a transaction is in progress
//   protocol_err_r          sticky protocol error flag
// -----------------------------------------------------------------------------
module dcache_blocking_mem_arb #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DAT_W  = 128,
  parameter int BEATS  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_wrbk,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ-1:0]          req_dat_valid,
  input  logic [N_REQ-1:0]          req_sop,
  input  logic [N_REQ-1:0]          req_eop,
  input  logic [N_REQ*DAT_W-1:0]    req_dat,
  output logic [N_REQ-1:0]          req_gnt_r,
  output logic [N_REQ-1:0]          rsp_valid_r,
  output logic                      rsp_sop_r,
  output logic                      rsp_eop_r,
  output logic [DAT_W-1:0]          rsp_dat_r,
  output logic                      mem_valid_r,
  output logic                      mem_wrbk_r,
  output logic [ADDR_W-1:0]         mem_addr_r,
  output logic                      mem_dat_valid_r,
  output logic                      mem_sop_r,
  output logic                      mem_eop_r,
  output logic [DAT_W-1:0]          mem_dat_r,
  input  logic                      mem_rsp_valid,
  input  logic                      mem_rsp_sop,
  input  logic                      mem_rsp_eop,
  input  logic [DAT_W-1:0]          mem_rsp_dat,
  output logic                      arb_busy_r,
  output logic                      protocol_err_r
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(BEATS);
  localparam logic [CW-1:0] CNT_LAST = CW'(BEATS - 1);
  localparam logic [N_REQ-1:0] ONE   = N_REQ'(1);

  typedef enum logic [1:0] {IDLE, WRBK, FILL} state_e;

  state_e             state_q, state_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      last_q, last_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic               rsp_sop_q, rsp_sop_d, rsp_eop_q, rsp_eop_d;
  logic [DAT_W-1:0]   rsp_dat_q, rsp_dat_d;
  logic               mem_valid_q, mem_valid_d, mem_wrbk_q, mem_wrbk_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               mem_dat_valid_q, mem_dat_valid_d;
  logic               mem_sop_q, mem_sop_d, mem_eop_q, mem_eop_d;
  logic [DAT_W-1:0]   mem_dat_q, mem_dat_d;

  // Round-robin winner: scan starting one past the last owner.
  logic               win_found;
  logic [OW-1:0]      win_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!win_found && req_valid[(int'(last_q) + i) % N_REQ]) begin
        win_found = 1'b1;
        win_idx   = OW'((int'(last_q) + i) % N_REQ);
      end
    end
  end

  // Owner's write-data beat.
  logic [N_REQ-1:0]   owner_oh;
  logic               own_dv, own_sop, own_eop;
  logic [DAT_W-1:0]   own_dat;

  assign owner_oh = ONE << owner_q;
  assign own_dv   = req_dat_valid[owner_q];
  assign own_sop  = req_sop[owner_q];
  assign own_eop  = req_eop[owner_q];
  assign own_dat  = req_dat[int'(owner_q)*DAT_W +: DAT_W];

  // A beat is malformed if eop disagrees with the beat position, or sop is
  // seen anywhere but on the first beat.
  function automatic logic beat_bad(input logic sop, input logic eop,
                                    input logic [CW-1:0] cnt);
    return (eop && cnt != CNT_LAST) || (!eop && cnt == CNT_LAST) ||
           (sop && cnt != '0);
  endfunction

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_d          = last_q;
    cnt_d           = cnt_q;
    err_d           = err_q;
    gnt_d           = '0;
    rsp_valid_d     = '0;
    rsp_sop_d       = 1'b0;
    rsp_eop_d       = 1'b0;
    rsp_dat_d       = '0;
    mem_valid_d     = 1'b0;
    mem_wrbk_d      = 1'b0;
    mem_addr_d      = '0;
    mem_dat_valid_d = 1'b0;
    mem_sop_d       = 1'b0;
    mem_eop_d       = 1'b0;
    mem_dat_d       = '0;

    unique case (state_q)
      IDLE: begin
        if (|req_dat_valid || mem_rsp_valid) err_d = 1'b1;
        if (win_found) begin
          gnt_d       = ONE << win_idx;
          mem_valid_d = 1'b1;
          mem_wrbk_d  = req_wrbk[win_idx];
          mem_addr_d  = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
          owner_d     = win_idx;
          last_d      = win_idx;
          cnt_d       = '0;
          state_d     = req_wrbk[win_idx] ? WRBK : FILL;
        end
      end

      WRBK: begin
        // Beats from anyone but the owner are dropped.
        if (mem_rsp_valid || |(req_dat_valid & ~owner_oh)) err_d = 1'b1;
        if (own_dv) begin
          mem_dat_valid_d = 1'b1;
          mem_sop_d       = own_sop;
          mem_eop_d       = own_eop;
          mem_dat_d       = own_dat;
          if (beat_bad(own_sop, own_eop, cnt_q)) err_d = 1'b1;
          cnt_d = own_eop ? '0 : cnt_q + CW'(1);
          if (own_eop) state_d = IDLE;
        end
      end

      FILL: begin
        if (|req_dat_valid) err_d = 1'b1;
        if (mem_rsp_valid) begin
          rsp_valid_d = owner_oh;
          rsp_sop_d   = mem_rsp_sop;
          rsp_eop_d   = mem_rsp_eop;
          rsp_dat_d   = mem_rsp_dat;
          if (beat_bad(mem_rsp_sop, mem_rsp_eop, cnt_q)) err_d = 1'b1;
          cnt_d = mem_rsp_eop ? '0 : cnt_q + CW'(1);
          if (mem_rsp_eop) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      owner_q         <= '0;
      last_q          <= OW'(N_REQ - 1);  // requester 0 wins first
      cnt_q           <= '0;
      err_q           <= 1'b0;
      gnt_q           <= '0;
      rsp_valid_q     <= '0;
      rsp_sop_q       <= 1'b0;
      rsp_eop_q       <= 1'b0;
      rsp_dat_q       <= '0;
      mem_valid_q     <= 1'b0;
      mem_wrbk_q      <= 1'b0;
      mem_addr_q      <= '0;
      mem_dat_valid_q <= 1'b0;
      mem_sop_q       <= 1'b0;
      mem_eop_q       <= 1'b0;
      mem_dat_q       <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      last_q          <= last_d;
      cnt_q           <= cnt_d;
      err_q           <= err_d;
      gnt_q           <= gnt_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_sop_q       <= rsp_sop_d;
      rsp_eop_q       <= rsp_eop_d;
      rsp_dat_q       <= rsp_dat_d;
      mem_valid_q     <= mem_valid_d;
      mem_wrbk_q      <= mem_wrbk_d;
      mem_addr_q      <= mem_addr_d;
      mem_dat_valid_q <= mem_dat_valid_d;
      mem_sop_q       <= mem_sop_d;
      mem_eop_q       <= mem_eop_d;
      mem_dat_q       <= mem_dat_d;
    end
  end

  assign req_gnt_r       = gnt_q;
  assign rsp_valid_r     = rsp_valid_q;
  assign rsp_sop_r       = rsp_sop_q;
  assign rsp_eop_r       = rsp_eop_q;
  assign rsp_dat_r       = rsp_dat_q;
  assign mem_valid_r     = mem_valid_q;
  assign mem_wrbk_r      = mem_wrbk_q;
  assign mem_addr_r      = mem_addr_q;
  assign mem_dat_valid_r = mem_dat_valid_q;
  assign mem_sop_r       = mem_sop_q;
  assign mem_eop_r       = mem_eop_q;
  assign mem_dat_r       = mem_dat_q;
  assign arb_busy_r      = (state_q != IDLE);
  assign protocol_err_r  = err_q;

endmodule

// File: tb/tb_dcache_blocking_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_dcache_blocking_mem_arb
//
// Directed bench for dcache_blocking_mem_arb with N_REQ=2, BEATS=4.
// Inputs change 1 ns after a rising edge, and outputs are sampled at the same
// point. A value sampled just after edge t+1 therefore reflects the inputs
// driven before edge t+1.
// -----------------------------------------------------------------------------
module tb_dcache_blocking_mem_arb;

  localparam int N_REQ  = 2;
  localparam int ADDR_W = 32;
  localparam int DAT_W  = 128;
  localparam int BEATS  = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [N_REQ-1:0]        req_valid = '0;
  logic [N_REQ-1:0]        req_wrbk = '0;
  logic [N_REQ*ADDR_W-1:0] req_addr = '0;
  logic [N_REQ-1:0]        req_dat_valid = '0;
  logic [N_REQ-1:0]        req_sop = '0;
  logic [N_REQ-1:0]        req_eop = '0;
  logic [N_REQ*DAT_W-1:0]  req_dat = '0;
  logic [N_REQ-1:0]        req_gnt_r;
  logic [N_REQ-1:0]        rsp_valid_r;
  logic                    rsp_sop_r, rsp_eop_r;
  logic [DAT_W-1:0]        rsp_dat_r;
  logic                    mem_valid_r, mem_wrbk_r;
  logic [ADDR_W-1:0]       mem_addr_r;
  logic                    mem_dat_valid_r, mem_sop_r, mem_eop_r;
  logic [DAT_W-1:0]        mem_dat_r;
  logic                    mem_rsp_valid = 1'b0;
  logic                    mem_rsp_sop = 1'b0;
  logic                    mem_rsp_eop = 1'b0;
  logic [DAT_W-1:0]        mem_rsp_dat = '0;
  logic                    arb_busy_r, protocol_err_r;

  int checks   = 0;
  int failures = 0;

  dcache_blocking_mem_arb #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DAT_W(DAT_W), .BEATS(BEATS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_wrbk(req_wrbk), .req_addr(req_addr),
    .req_dat_valid(req_dat_valid), .req_sop(req_sop), .req_eop(req_eop),
    .req_dat(req_dat),
    .req_gnt_r(req_gnt_r), .rsp_valid_r(rsp_valid_r),
    .rsp_sop_r(rsp_sop_r), .rsp_eop_r(rsp_eop_r), .rsp_dat_r(rsp_dat_r),
    .mem_valid_r(mem_valid_r), .mem_wrbk_r(mem_wrbk_r), .mem_addr_r(mem_addr_r),
    .mem_dat_valid_r(mem_dat_valid_r), .mem_sop_r(mem_sop_r),
    .mem_eop_r(mem_eop_r), .mem_dat_r(mem_dat_r),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_sop(mem_rsp_sop),
    .mem_rsp_eop(mem_rsp_eop), .mem_rsp_dat(mem_rsp_dat),
    .arb_busy_r(arb_busy_r), .protocol_err_r(protocol_err_r)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DAT_W-1:0] observed,
                       input logic [DAT_W-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_beats();
    req_dat_valid = '0;
    req_sop       = '0;
    req_eop       = '0;
    req_dat       = '0;
    mem_rsp_valid = 1'b0;
    mem_rsp_sop   = 1'b0;
    mem_rsp_eop   = 1'b0;
    mem_rsp_dat   = '0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"},  req_gnt_r, '0);
    check({tag, "_mval"}, mem_valid_r, 1'b0);
    check({tag, "_addr"}, mem_addr_r, '0);
    check({tag, "_mdv"},  mem_dat_valid_r, 1'b0);
    check({tag, "_rsp"},  rsp_valid_r, '0);
    check({tag, "_rdat"}, rsp_dat_r, '0);
    check({tag, "_busy"}, arb_busy_r, 1'b0);
    check({tag, "_err"},  protocol_err_r, 1'b0);
  endtask

  // Memory drives one response beat.
  task automatic rsp_beat(input logic sop, input logic eop,
                          input logic [DAT_W-1:0] dat);
    mem_rsp_valid = 1'b1;
    mem_rsp_sop   = sop;
    mem_rsp_eop   = eop;
    mem_rsp_dat   = dat;
  endtask

  // Requester r drives one write beat.
  task automatic wr_beat(input int r, input logic sop, input logic eop,
                         input logic [DAT_W-1:0] dat);
    req_dat_valid[r]            = 1'b1;
    req_sop[r]                  = sop;
    req_eop[r]                  = eop;
    req_dat[r*DAT_W +: DAT_W]   = dat;
  endtask

  logic [DAT_W-1:0] d_base;
  logic [N_REQ-1:0] exp_gnt;

  initial begin
    d_base = {32'hDEAD_0000, 32'h1111_2222, 32'h3333_4444, 32'h5555_0000};

    // ---------------- reset state ----------------
    tick();
    tick();
    check_idle_outputs("reset");
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_gnt", req_gnt_r, '0);

    // ---------------- fill, requester 0 ----------------
    req_valid = 2'b01;
    req_wrbk  = 2'b00;
    req_addr[0 +: ADDR_W] = 32'h0000_1000;
    tick();
    check("f0_gnt",  req_gnt_r, 2'b01);
    check("f0_mval", mem_valid_r, 1'b1);
    check("f0_wrbk", mem_wrbk_r, 1'b0);
    check("f0_addr", mem_addr_r, 32'h0000_1000);
    check("f0_busy", arb_busy_r, 1'b1);
    req_valid = 2'b00;
    tick();
    check("f0_gnt_pulse",  req_gnt_r, 2'b00);
    check("f0_mval_pulse", mem_valid_r, 1'b0);
    for (int k = 0; k < BEATS; k++) begin
      rsp_beat(k == 0, k == BEATS - 1, d_base + DAT_W'(k));
      tick();
      check("f0_rsp_valid", rsp_valid_r, 2'b01);
      check("f0_rsp_sop",   rsp_sop_r, k == 0);
      check("f0_rsp_eop",   rsp_eop_r, k == BEATS - 1);
      check("f0_rsp_dat",   rsp_dat_r, d_base + DAT_W'(k));
    end
    clear_beats();
    check("f0_busy_end", arb_busy_r, 1'b0);
    check("f0_err",      protocol_err_r, 1'b0);
    tick();
    check("f0_rsp_gone", rsp_valid_r, 2'b00);

    // ---------------- round-robin, both requesters hold fills ----------------
    // Last owner is 0, so requester 1 wins first.
    req_valid = 2'b11;
    req_wrbk  = 2'b00;
    req_addr  = {32'h0000_4000, 32'h0000_3000};
    exp_gnt   = 2'b10;
    tick();
    for (int t = 0; t < 4; t++) begin
      check("rr_gnt",  req_gnt_r, exp_gnt);
      check("rr_addr", mem_addr_r, exp_gnt[1] ? 32'h0000_4000 : 32'h0000_3000);
      for (int k = 0; k < BEATS; k++) begin
        rsp_beat(k == 0, k == BEATS - 1, DAT_W'(t * 16 + k));
        tick();
        check("rr_rsp_valid", rsp_valid_r, exp_gnt);
        if (k < BEATS - 1) check("rr_no_double_gnt", req_gnt_r, 2'b00);
      end
      clear_beats();
      // Forwarded eop cycle: no grant yet, one idle cycle to the next grant.
      check("rr_eop",     rsp_eop_r, 1'b1);
      check("rr_gap_gnt", req_gnt_r, 2'b00);
      if (t == 3) req_valid = 2'b00;
      tick();
      exp_gnt = ~exp_gnt;
    end
    check("rr_stop_gnt", req_gnt_r, 2'b00);

    // ---------------- writeback, requester 1 ----------------
    req_valid = 2'b10;
    req_wrbk  = 2'b10;
    req_addr[ADDR_W +: ADDR_W] = 32'h0000_2040;
    tick();
    check("w1_gnt",  req_gnt_r, 2'b10);
    check("w1_mval", mem_valid_r, 1'b1);
    check("w1_wrbk", mem_wrbk_r, 1'b1);
    check("w1_addr", mem_addr_r, 32'h0000_2040);
    req_valid = 2'b00;
    for (int k = 0; k < BEATS; k++) begin
      wr_beat(1, k == 0, k == BEATS - 1, d_base ^ DAT_W'(k + 'hA0));
      tick();
      check("w1_mdv",  mem_dat_valid_r, 1'b1);
      check("w1_msop", mem_sop_r, k == 0);
      check("w1_meop", mem_eop_r, k == BEATS - 1);
      check("w1_mdat", mem_dat_r, d_base ^ DAT_W'(k + 'hA0));
      check("w1_rsp",  rsp_valid_r, 2'b00);
    end
    clear_beats();
    check("w1_busy_end", arb_busy_r, 1'b0);
    check("w1_err",      protocol_err_r, 1'b0);

    // ---------------- non-owner write beat during requester 0 writeback ------
    req_valid = 2'b01;
    req_wrbk  = 2'b01;
    req_addr[0 +: ADDR_W] = 32'h0000_5000;
    tick();
    check("nw_gnt", req_gnt_r, 2'b01);
    req_valid = 2'b00;
    for (int k = 0; k < BEATS; k++) begin
      clear_beats();
      wr_beat(0, k == 0, k == BEATS - 1, DAT_W'(32'h5000 + k));
      if (k == 1) wr_beat(1, 1'b0, 1'b0, DAT_W'(32'hBAD));
      tick();
      check("nw_mdat", mem_dat_r, DAT_W'(32'h5000 + k));
      check("nw_meop", mem_eop_r, k == BEATS - 1);
      if (k == 1) check("nw_err", protocol_err_r, 1'b1);
    end
    clear_beats();
    check("nw_busy_end", arb_busy_r, 1'b0);
    check("nw_err_sticky", protocol_err_r, 1'b1);

    // ---------------- short burst after a fresh reset ----------------
    rst_n = 1'b0;
    #2;
    check("rst2_err", protocol_err_r, 1'b0);
    rst_n = 1'b1;
    req_valid = 2'b01;
    req_wrbk  = 2'b00;
    req_addr[0 +: ADDR_W] = 32'h0000_6000;
    tick();
    check("sb_gnt", req_gnt_r, 2'b01);
    req_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      rsp_beat(k == 0, k == 2, DAT_W'(32'h6000 + k));
      tick();
      check("sb_rsp_dat", rsp_dat_r, DAT_W'(32'h6000 + k));
    end
    clear_beats();
    check("sb_eop",  rsp_eop_r, 1'b1);
    check("sb_busy", arb_busy_r, 1'b0);
    check("sb_err",  protocol_err_r, 1'b1);

    // ---------------- reset mid-fill ----------------
    tick();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    check("rm_err_clr", protocol_err_r, 1'b0);
    req_valid = 2'b01;
    req_addr[0 +: ADDR_W] = 32'h0000_7000;
    tick();
    check("rm_gnt", req_gnt_r, 2'b01);
    req_valid = 2'b00;
    for (int k = 0; k < 2; k++) begin
      rsp_beat(k == 0, 1'b0, DAT_W'(32'h7000 + k));
      tick();
      check("rm_rsp_valid", rsp_valid_r, 2'b01);
    end
    #2 rst_n = 1'b0;
    clear_beats();
    #1;
    check_idle_outputs("rm_async");
    // Requester 1 asks with requester 0 also pending: requester 0 goes first.
    req_valid = 2'b11;
    req_wrbk  = 2'b00;
    req_addr  = {32'h0000_8100, 32'h0000_8000};
    tick();
    check("rm_held_gnt", req_gnt_r, 2'b00);
    #1 rst_n = 1'b1;
    tick();
    check("rm_first_gnt",  req_gnt_r, 2'b01);
    check("rm_first_addr", mem_addr_r, 32'h0000_8000);
    req_valid = 2'b10;
    for (int k = 0; k < BEATS; k++) begin
      rsp_beat(k == 0, k == BEATS - 1, DAT_W'(k));
      tick();
    end
    clear_beats();
    tick();
    check("rm_second_gnt", req_gnt_r, 2'b10);
    req_valid = 2'b00;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
